data_mem_ctl: RTL and testbench
===============================

DATA_MEM_CTL -- requirements
Module: data_mem_ctl

Interface
REQ-001 Parameter DW, default 8, data width in bits.
REQ-002 Parameter AW, default 8, address width; depth = 2**AW words.
REQ-003 Parameter WIN, default 4, number of low words mirrored on the Win port (1..2**AW).
REQ-004 Parameter RD_LAT, default 1, read latency in cycles; legal values are 0 and 1 only.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 DataAddress  input  AW  word address for read and write.
REQ-008 ReadMem  input  1  read request, sampled each cycle.
REQ-009 WriteMem  input  1  write request, sampled each cycle.
REQ-010 DataIn  input  DW  write data.
REQ-011 DataOut  output  DW  read data.
REQ-012 RdValid  output  1  DataOut holds the result of an accepted read.
REQ-013 Busy  output  1  clear sequence in progress; requests are ignored.
REQ-014 Win  output  WIN*DW  live copy of words 0..WIN-1; word i at bits [i*DW +: DW].

Function
REQ-015 States SHALL be CLEAR and RUN; the next state is CLEAR whenever Reset is sampled high.
REQ-016 Clear counter: held at 0 while Reset is high; in CLEAR with Reset low, each cycle writes 0 to Mem[cnt] and increments cnt.
REQ-017 The cycle that writes address 2**AW-1 SHALL move the state to RUN, so Busy stays high for exactly 2**AW cycles after Reset falls.
REQ-018 Busy SHALL be 1 in CLEAR and 0 in RUN.
REQ-019 In CLEAR, ReadMem and WriteMem SHALL be ignored: no write, RdValid=0, DataOut unchanged.
REQ-020 Write in RUN: when WriteMem=1, Mem[DataAddress] takes DataIn at the rising edge.
REQ-021 RD_LAT=1: when ReadMem=1 in RUN, DataOut is registered with Mem[DataAddress] and RdValid=1 on the following cycle; otherwise RdValid=0 and DataOut holds its last value.
REQ-022 RD_LAT=0: DataOut = Mem[DataAddress] combinationally; RdValid = ReadMem & ~Busy.
REQ-023 Simultaneous read and write to the same address (RD_LAT=1) SHALL return the old data (read-before-write).
REQ-024 Back-to-back reads SHALL be accepted every cycle, with no bubbles.
REQ-025 Win[i] SHALL update on the same edge as any write (user or clear) to address i < WIN, and is never written otherwise.
REQ-026 Addresses wrap naturally within AW bits; no out-of-range case exists.
REQ-027 Reset asserted mid-clear or mid-RUN SHALL abandon in-flight reads (RdValid=0 next cycle) and restart the clear from address 0.

Reset
REQ-028 While Reset is high: state=CLEAR, cnt=0, Busy=1, RdValid=0, registered DataOut=0.
REQ-029 Memory and Win contents SHALL be undefined only until the clear sequence completes; after Busy falls, all words read 0.

Structure
REQ-030 Package data_mem_pkg SHALL hold the state enum (CLEAR, RUN) and the default values of DW, AW, WIN and RD_LAT.
REQ-031 Storage SHALL be a sub-module data_mem_array: one synchronous write port, one asynchronous read port, parametrised by DW and AW.
REQ-032 The FSM, clear counter, read register and Win mirror SHALL live in data_mem_ctl.

Verification
REQ-033 Reset 3 cycles, then release -> Busy=1 for exactly 256 cycles (AW=8); reads of 0x00, 0x7F and 0xFF then return 0x00.
REQ-034 RD_LAT=1: write 0xA5 to 0x10, then read 0x10 -> DataOut=0xA5 with RdValid=1 exactly one cycle after the read.
REQ-035 Mem[0x20]=0x11; same cycle ReadMem=1, WriteMem=1, DataIn=0x22 at 0x20 -> DataOut=0x11; a next read returns 0x22.
REQ-036 Writes 0x01..0x04 to addresses 0..3 -> Win=0x04030201 on the edge of the last write; a write to address 4 leaves Win unchanged.
REQ-037 Reset at clear cycle 100 -> after release, Busy=1 for a full 256 cycles; a write attempted while Busy is dropped.
REQ-038 RD_LAT=0: reads of addresses 0..7 on consecutive cycles -> DataOut matches in the same cycle and RdValid=1 throughout.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared defaults and FSM state encoding for the data memory controller.
package data_mem_pkg;

    localparam int DW_DEF     = 8;
    localparam int AW_DEF     = 8;
    localparam int WIN_DEF    = 4;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed storage: one synchronous write port, one asynchronous read port.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_ctl.sv
// Data memory controller: zero-fill after reset, read/write access, and a live
// mirror of the lowest WIN words.
module data_mem_ctl
    import data_mem_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int WIN    = WIN_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [AW-1:0]     DataAddress,
    input  logic              ReadMem,
    input  logic              WriteMem,
    input  logic [DW-1:0]     DataIn,
    output logic [DW-1:0]     DataOut,
    output logic              RdValid,
    output logic              Busy,
    output logic [WIN*DW-1:0] Win
);

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic          clearing;
    logic          run;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] win_q [WIN];

    assign Busy     = (state_q == CLEAR);
    assign clearing = (state_q == CLEAR) && !Reset;
    assign run      = (state_q == RUN) && !Reset;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else if (state_q == CLEAR) begin
            cnt_q <= cnt_q + AW'(1);
            if (cnt_q == {AW{1'b1}}) state_q <= RUN;
        end
    end

    // The clear sequence owns the write port; user requests only reach it in RUN.
    always_comb begin
        we    = 1'b0;
        waddr = DataAddress;
        wdata = DataIn;
        if (clearing) begin
            we    = 1'b1;
            waddr = cnt_q;
            wdata = '0;
        end else if (run && WriteMem) begin
            we = 1'b1;
        end
    end

    data_mem_array #(
        .DW(DW),
        .AW(AW)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(DataAddress),
        .rdata(rd_data)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < WIN; i++) begin
            if (we && waddr == AW'(i)) win_q[i] <= wdata;
        end
    end

    for (genvar g = 0; g < WIN; g++) begin : g_win
        assign Win[g*DW +: DW] = win_q[g];
    end

    if (RD_LAT == 0) begin : g_rd_comb
        assign DataOut = rd_data;
        assign RdValid = ReadMem & ~Busy;
    end else begin : g_rd_reg
        logic [DW-1:0] dout_p1;
        logic          vld_p1;

        // p0 -> p1: async array read captured; old data wins over a same-edge write
        always_ff @(posedge clk) begin
            if (Reset) begin
                dout_p1 <= '0;
                vld_p1  <= 1'b0;
            end else if (run && ReadMem) begin
                dout_p1 <= rd_data;
                vld_p1  <= 1'b1;
            end else begin
                vld_p1  <= 1'b0;
            end
        end

        assign DataOut = dout_p1;
        assign RdValid = vld_p1;
    end

endmodule

// File: tb/tb_data_mem_ctl.sv
// Directed bench driving a registered-read and a combinational-read instance in lockstep.
module tb_data_mem_ctl;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  DataAddress = '0;
    logic        ReadMem = 1'b0;
    logic        WriteMem = 1'b0;
    logic [7:0]  DataIn = '0;

    logic [7:0]  dout1, dout0;
    logic        vld1, vld0;
    logic        busy1, busy0;
    logic [31:0] win1, win0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_ctl #(.DW(8), .AW(8), .WIN(4), .RD_LAT(1)) dut1 (
        .clk(clk), .Reset(Reset), .DataAddress(DataAddress), .ReadMem(ReadMem),
        .WriteMem(WriteMem), .DataIn(DataIn), .DataOut(dout1), .RdValid(vld1),
        .Busy(busy1), .Win(win1)
    );

    data_mem_ctl #(.DW(8), .AW(8), .WIN(4), .RD_LAT(0)) dut0 (
        .clk(clk), .Reset(Reset), .DataAddress(DataAddress), .ReadMem(ReadMem),
        .WriteMem(WriteMem), .DataIn(DataIn), .DataOut(dout0), .RdValid(vld0),
        .Busy(busy0), .Win(win0)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] a, input logic [7:0] d);
        DataAddress = a;
        DataIn      = d;
        WriteMem    = 1'b1;
        step();
        WriteMem    = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        logic [7:0] addrs [3];
        addrs = '{8'h00, 8'h7F, 8'hFF};
        Reset = 1'b1;
        ReadMem = 1'b1;
        repeat (3) step();
        checks++;
        if (busy1 !== 1'b1 || vld1 !== 1'b0 || dout1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: busy=%b vld=%b dout=%h, want busy=1 vld=0 dout=00", busy1, vld1, dout1);
        end
        checks++;
        if (busy0 !== 1'b1 || vld0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_comb: busy=%b vld=%b, want 1 0", busy0, vld0);
        end
        ReadMem = 1'b0;
        Reset = 1'b0;
        n = 0;
        while (busy1 === 1'b1 && n < 1000) begin
            n++;
            checks++;
            if (vld1 !== 1'b0) begin
                errors++;
                $display("FAIL clear_no_valid: vld=%b at clear cycle %0d, want 0", vld1, n);
            end
            ReadMem = (n == 20);
            step();
        end
        ReadMem = 1'b0;
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL busy_len: busy for %0d cycles, want 256", n);
        end
        checks++;
        if (busy0 !== 1'b0 || win1 !== 32'h0 || win0 !== 32'h0) begin
            errors++;
            $display("FAIL after_clear: busy0=%b win1=%h win0=%h, want 0 0 0", busy0, win1, win0);
        end
        for (int i = 0; i < 3; i++) begin
            DataAddress = addrs[i];
            ReadMem = 1'b1;
            #1;
            checks++;
            if (dout0 !== 8'h00 || vld0 !== 1'b1) begin
                errors++;
                $display("FAIL clear_read_comb[%h]: dout=%h vld=%b, want 00 1", addrs[i], dout0, vld0);
            end
            step();
            ReadMem = 1'b0;
            checks++;
            if (dout1 !== 8'h00 || vld1 !== 1'b1) begin
                errors++;
                $display("FAIL clear_read[%h]: dout=%h vld=%b, want 00 1", addrs[i], dout1, vld1);
            end
        end
    endtask

    task automatic test_write_read;
        write_word(8'h10, 8'hA5);
        DataAddress = 8'h10;
        ReadMem = 1'b1;
        #1;
        checks++;
        if (dout0 !== 8'hA5 || vld0 !== 1'b1) begin
            errors++;
            $display("FAIL wr_rd_comb: dout=%h vld=%b, want a5 1", dout0, vld0);
        end
        checks++;
        if (vld1 !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_early: vld=%b before edge, want 0", vld1);
        end
        step();
        ReadMem = 1'b0;
        checks++;
        if (dout1 !== 8'hA5 || vld1 !== 1'b1) begin
            errors++;
            $display("FAIL wr_rd: dout=%h vld=%b, want a5 1", dout1, vld1);
        end
        DataAddress = 8'h00;
        step();
        checks++;
        if (dout1 !== 8'hA5 || vld1 !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_hold: dout=%h vld=%b, want a5 0", dout1, vld1);
        end
    endtask

    task automatic test_read_before_write;
        write_word(8'h20, 8'h11);
        DataAddress = 8'h20;
        DataIn = 8'h22;
        ReadMem = 1'b1;
        WriteMem = 1'b1;
        #1;
        checks++;
        if (dout0 !== 8'h11) begin
            errors++;
            $display("FAIL rbw_comb: dout=%h, want 11", dout0);
        end
        step();
        WriteMem = 1'b0;
        checks++;
        if (dout1 !== 8'h11 || vld1 !== 1'b1) begin
            errors++;
            $display("FAIL rbw_old: dout=%h vld=%b, want 11 1", dout1, vld1);
        end
        step();
        ReadMem = 1'b0;
        checks++;
        if (dout1 !== 8'h22 || vld1 !== 1'b1) begin
            errors++;
            $display("FAIL rbw_new: dout=%h vld=%b, want 22 1", dout1, vld1);
        end
    endtask

    task automatic test_win;
        write_word(8'h00, 8'h01);
        write_word(8'h01, 8'h02);
        write_word(8'h02, 8'h03);
        checks++;
        if (win1 !== 32'h00030201) begin
            errors++;
            $display("FAIL win_partial: win=%h, want 00030201", win1);
        end
        write_word(8'h03, 8'h04);
        checks++;
        if (win1 !== 32'h04030201 || win0 !== 32'h04030201) begin
            errors++;
            $display("FAIL win_full: win1=%h win0=%h, want 04030201", win1, win0);
        end
        write_word(8'h04, 8'h55);
        checks++;
        if (win1 !== 32'h04030201) begin
            errors++;
            $display("FAIL win_addr4: win=%h, want 04030201", win1);
        end
        DataAddress = 8'h04;
        #1;
        checks++;
        if (dout0 !== 8'h55) begin
            errors++;
            $display("FAIL addr4_stored: dout=%h, want 55", dout0);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) write_word(8'(i), 8'(8'h10 + i * 8'h11));
        checks++;
        if (win1 !== 32'h43322110) begin
            errors++;
            $display("FAIL win_b2b: win=%h, want 43322110", win1);
        end
        ReadMem = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = 8'(8'h10 + i * 8'h11);
            DataAddress = 8'(i);
            #1;
            checks++;
            if (dout0 !== exp || vld0 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_comb[%0d]: dout=%h vld=%b, want %h 1", i, dout0, vld0, exp);
            end
            step();
            checks++;
            if (dout1 !== exp || vld1 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_reg[%0d]: dout=%h vld=%b, want %h 1", i, dout1, vld1, exp);
            end
        end
        ReadMem = 1'b0;
    endtask

    task automatic test_reset_mid_clear;
        int n;
        DataAddress = 8'h10;
        ReadMem = 1'b1;
        Reset = 1'b1;
        step();
        checks++;
        if (vld1 !== 1'b0 || busy1 !== 1'b1 || dout1 !== 8'h00) begin
            errors++;
            $display("FAIL mid_run_reset: vld=%b busy=%b dout=%h, want 0 1 00", vld1, busy1, dout1);
        end
        ReadMem = 1'b0;
        Reset = 1'b0;
        repeat (100) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        n = 0;
        while (busy1 === 1'b1 && n < 1000) begin
            n++;
            DataAddress = 8'h02;
            DataIn = 8'h77;
            WriteMem = (n == 10);
            step();
        end
        WriteMem = 1'b0;
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL busy_len_restart: busy for %0d cycles, want 256", n);
        end
        checks++;
        if (win1 !== 32'h0) begin
            errors++;
            $display("FAIL busy_write_win: win=%h, want 00000000", win1);
        end
        DataAddress = 8'h02;
        #1;
        checks++;
        if (dout0 !== 8'h00) begin
            errors++;
            $display("FAIL busy_write_dropped: dout=%h, want 00", dout0);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_before_write();
        test_win();
        test_back_to_back();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
